// File: rtl/kid_motion.sv
// Kid player controller: walk, gravity, multi-jump with variable height, screen limits,
// and a registered per-pixel sprite hit test. Define KID_WRAP_EN for horizontal wrap-around.
module kid_motion #(
  parameter int SCREEN_W  = 640,
  parameter int KID_W     = 16,
  parameter int KID_H     = 16,
  parameter int FLOOR_Y   = 448,
  parameter int START_X   = 32,
  parameter int WALK_V    = 2,
  parameter int JUMP_V    = 8,
  parameter int GRAVITY   = 1,
  parameter int MAX_FALL  = 9,
  parameter int MAX_JUMPS = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        update_tick,
  input  logic [3:0]  keys,
  input  logic [9:0]  col,
  input  logic [9:0]  row,
  output logic        is_kid,
  output logic [11:0] kid_rgb,
  output logic [9:0]  kid_x,
  output logic [9:0]  kid_y,
  output logic        on_ground,
  output logic [2:0]  jumps_left
);

  typedef enum logic {GROUND, AIR} state_t;

  localparam logic signed [10:0] Y_GND   = 11'(FLOOR_Y - KID_H);
  localparam logic signed [10:0] X_MAX   = 11'(SCREEN_W - KID_W);
  localparam logic signed [10:0] X_START = 11'(START_X);
  localparam logic signed [10:0] X_STEP  = 11'(WALK_V);
  localparam logic signed [7:0]  VY_JUMP = 8'(-JUMP_V);
  localparam logic signed [7:0]  VY_GRAV = 8'(GRAVITY);
  localparam logic signed [7:0]  VY_MAXF = 8'(MAX_FALL);
  localparam logic [2:0]         JL_MAX  = 3'(MAX_JUMPS);
  localparam logic [10:0]        W_SPR   = 11'(KID_W);
  localparam logic [10:0]        H_SPR   = 11'(KID_H);

  state_t             r_state, w_state;
  logic signed [10:0] r_x, r_y, w_x, w_y;
  logic signed [5:0]  r_vy, w_vy;
  logic [2:0]         r_jl, w_jl;
  logic               r_key_q, r_jump_pend, r_rel_pend;
  logic               r_is_kid;
  logic [11:0]        r_rgb;

  logic               w_rise, w_fall, w_jump, w_rel;
  logic signed [7:0]  w_vy_t;
  logic signed [10:0] w_y_t, w_x_t;
  logic [10:0]        w_xu, w_yu, w_col, w_row;
  logic               w_hit;

  // An edge arriving on the tick clock itself is honoured rather than lost.
  assign w_rise = keys[1] & ~r_key_q;
  assign w_fall = ~keys[1] & r_key_q;
  assign w_jump = r_jump_pend | w_rise;
  assign w_rel  = r_rel_pend | w_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= GROUND;
      r_x         <= X_START;
      r_y         <= Y_GND;
      r_vy        <= '0;
      r_jl        <= JL_MAX;
      r_key_q     <= 1'b0;
      r_jump_pend <= 1'b0;
      r_rel_pend  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_x     <= w_x;
      r_y     <= w_y;
      r_vy    <= w_vy;
      r_jl    <= w_jl;
      r_key_q <= keys[1];
      if (update_tick) begin
        r_jump_pend <= 1'b0;
        r_rel_pend  <= 1'b0;
      end else begin
        r_jump_pend <= r_jump_pend | w_rise;
        r_rel_pend  <= r_rel_pend | w_fall;
      end
    end
  end

  always_comb begin
    w_state = r_state;
    w_x     = r_x;
    w_y     = r_y;
    w_vy    = r_vy;
    w_jl    = r_jl;
    w_vy_t  = {{2{r_vy[5]}}, r_vy};
    w_y_t   = r_y;
    w_x_t   = r_x;
    if (update_tick) begin
      if (keys[3]) begin
        w_state = GROUND;
        w_x     = X_START;
        w_y     = Y_GND;
        w_vy    = '0;
        w_jl    = JL_MAX;
      end else begin
        if (w_jump && (r_jl != '0)) begin
          w_vy_t  = VY_JUMP;
          w_jl    = r_jl - 3'd1;
          w_state = AIR;
        end else if (r_state == AIR) begin
          if (w_rel && w_vy_t[7])
            w_vy_t = -((-w_vy_t) >>> 1);
          w_vy_t = w_vy_t + VY_GRAV;
          if (w_vy_t > VY_MAXF)
            w_vy_t = VY_MAXF;
        end
        w_y_t = r_y + {{3{w_vy_t[7]}}, w_vy_t};
        w_y   = w_y_t;
        w_vy  = w_vy_t[5:0];
        if (w_y_t >= Y_GND) begin
          w_y     = Y_GND;
          w_vy    = '0;
          w_state = GROUND;
          w_jl    = JL_MAX;
        end else if (w_y_t[10]) begin
          w_y  = '0;
          w_vy = '0;
        end
        if (keys[0] && !keys[2]) begin
          w_x_t = r_x - X_STEP;
`ifdef KID_WRAP_EN
          w_x = w_x_t[10] ? X_MAX : w_x_t;
`else
          w_x = w_x_t[10] ? '0 : w_x_t;
`endif
        end else if (keys[2] && !keys[0]) begin
          w_x_t = r_x + X_STEP;
`ifdef KID_WRAP_EN
          w_x = (w_x_t > X_MAX) ? '0 : w_x_t;
`else
          w_x = (w_x_t > X_MAX) ? X_MAX : w_x_t;
`endif
        end
      end
    end
  end

  assign w_xu  = r_x;
  assign w_yu  = r_y;
  assign w_col = {1'b0, col};
  assign w_row = {1'b0, row};
  assign w_hit = (w_col >= w_xu) && (w_col < w_xu + W_SPR) &&
                 (w_row >= w_yu) && (w_row < w_yu + H_SPR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_is_kid <= 1'b0;
      r_rgb    <= '0;
    end else begin
      r_is_kid <= w_hit;
      r_rgb    <= w_hit ? ((r_state == GROUND) ? 12'hFFF : 12'hFC0) : '0;
    end
  end

  assign is_kid     = r_is_kid;
  assign kid_rgb    = r_rgb;
  assign kid_x      = r_x[9:0];
  assign kid_y      = r_y[9:0];
  assign on_ground  = (r_state == GROUND);
  assign jumps_left = r_jl;

endmodule

// File: tb/tb_kid_motion.sv
// Self-checking bench for kid_motion: vector tables for hit test and jump physics,
// hand-written sequences for walking limits, restart and asynchronous reset.
module tb_kid_motion;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        update_tick = 1'b0;
  logic [3:0]  keys = '0;
  logic [9:0]  col = '0;
  logic [9:0]  row = '0;
  logic        is_kid;
  logic [11:0] kid_rgb;
  logic [9:0]  kid_x, kid_y;
  logic        on_ground;
  logic [2:0]  jumps_left;

  int n_cmp = 0;
  int n_bad = 0;

  kid_motion dut (
    .clk(clk), .rst_n(rst_n), .update_tick(update_tick), .keys(keys),
    .col(col), .row(row), .is_kid(is_kid), .kid_rgb(kid_rgb),
    .kid_x(kid_x), .kid_y(kid_y), .on_ground(on_ground), .jumps_left(jumps_left)
  );

  always #5 clk = ~clk;

  typedef struct { logic [3:0] k; bit bounce; int x; int y; bit og; int jl; } vec_t;
  typedef struct { int col; int row; bit hit; int rgb; } hvec_t;
  typedef struct { string nm; int x; int y; bit og; int jl; } exp_t;

  vec_t  tbl[$];
  hvec_t htbl[$];
  exp_t  exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // Drive one frame: keys settle for a clock, then a one-clock update_tick.
  task automatic run_step(input string nm, input logic [3:0] k, input bit bounce,
                          input int ex, input int ey, input bit eog, input int ejl);
    exp_t e;
    if (bounce) begin
      keys = k & 4'b1101;
      @(negedge clk);
    end
    keys = k;
    @(negedge clk);
    e.nm = nm; e.x = ex; e.y = ey; e.og = eog; e.jl = ejl;
    exp_q.push_back(e);
    update_tick = 1'b1;
    @(negedge clk);
    update_tick = 1'b0;
    #1;
    if (exp_q.size() == 0) begin
      chk({nm, ".queue"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({e.nm, ".x"}, 32'(kid_x), 32'(e.x));
      chk({e.nm, ".y"}, 32'(kid_y), 32'(e.y));
      chk({e.nm, ".og"}, 32'(on_ground), 32'(e.og));
      chk({e.nm, ".jl"}, 32'(jumps_left), 32'(e.jl));
    end
  endtask

  task automatic add(input logic [3:0] k, input bit b, input int y, input bit og, input int jl);
    vec_t v;
    v.k = k; v.bounce = b; v.x = 32; v.y = y; v.og = og; v.jl = jl;
    tbl.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ex;
    int hold_y[17];
    int var_y[11];
    int dbl_y[19];
    hold_y = '{424, 417, 411, 406, 402, 399, 397, 396, 396, 397, 399, 402, 406, 411, 417, 424, 432};
    var_y  = '{424, 417, 415, 414, 414, 415, 417, 420, 424, 429, 432};
    dbl_y  = '{424, 417, 411, 406, 402, 394, 391, 389, 388, 388, 389, 391, 394, 398, 403, 409, 416, 424, 432};

    // held jump: full arc
    for (int i = 0; i < 17; i++)
      add(4'b0010, 1'b0, hold_y[i], (i == 16), (i == 16) ? 2 : 1);
    add(4'b0010, 1'b0, 432, 1'b1, 2);
    add(4'b0000, 1'b0, 432, 1'b1, 2);
    // released between tick2 and tick3
    for (int i = 0; i < 11; i++)
      add((i < 2) ? 4'b0010 : 4'b0000, 1'b0, var_y[i], (i == 10), (i == 10) ? 2 : 1);
    // double jump, then a press with no jumps left
    for (int i = 0; i < 19; i++) begin
      logic [3:0] k;
      int jl;
      k  = (i == 6) ? 4'b0000 : 4'b0010;
      jl = (i < 5) ? 1 : 0;
      if (i == 18) jl = 2;
      add(k, (i == 5), dbl_y[i], (i == 18), jl);
    end
    add(4'b0000, 1'b0, 432, 1'b1, 2);

    htbl.push_back('{32, 432, 1'b1, 12'hFFF});
    htbl.push_back('{47, 447, 1'b1, 12'hFFF});
    htbl.push_back('{48, 432, 1'b0, 0});
    htbl.push_back('{31, 432, 1'b0, 0});
    htbl.push_back('{32, 431, 1'b0, 0});
    htbl.push_back('{40, 448, 1'b0, 0});
    htbl.push_back('{40, 440, 1'b1, 12'hFFF});
    htbl.push_back('{0, 0, 1'b0, 0});

    repeat (3) @(negedge clk);
    chk("rst.x", 32'(kid_x), 32'd32);
    chk("rst.y", 32'(kid_y), 32'd432);
    chk("rst.og", 32'(on_ground), 32'd1);
    chk("rst.jl", 32'(jumps_left), 32'd2);
    chk("rst.is_kid", 32'(is_kid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    col = 10'd32; row = 10'd432;
    #1;
    chk("hit.latency", 32'(is_kid), 32'd0);
    @(negedge clk);
    chk("hit.first", 32'(is_kid), 32'd1);

    foreach (htbl[i]) begin
      col = 10'(htbl[i].col);
      row = 10'(htbl[i].row);
      @(negedge clk);
      chk($sformatf("hit[%0d].is_kid", i), 32'(is_kid), 32'(htbl[i].hit));
      chk($sformatf("hit[%0d].rgb", i), 32'(kid_rgb), 32'(htbl[i].rgb));
    end

    foreach (tbl[i])
      run_step($sformatf("vec[%0d]", i), tbl[i].k, tbl[i].bounce, tbl[i].x, tbl[i].y, tbl[i].og, tbl[i].jl);

    // walk left into the edge
    for (int i = 1; i <= 18; i++) begin
      ex = 32 - 2 * i;
`ifdef KID_WRAP_EN
      if (i == 17) ex = 624;
      if (i == 18) ex = 622;
`else
      if (ex < 0) ex = 0;
`endif
      run_step($sformatf("left[%0d]", i), 4'b0001, 1'b0, ex, 432, 1'b1, 2);
    end
    run_step("both", 4'b0101, 1'b0, ex, 432, 1'b1, 2);
    run_step("neither", 4'b0000, 1'b0, ex, 432, 1'b1, 2);

    // walk right into the edge
`ifdef KID_WRAP_EN
    for (int i = 1; i <= 3; i++) begin
      ex = (ex + 2 > 624) ? 0 : ex + 2;
      run_step($sformatf("right[%0d]", i), 4'b0100, 1'b0, ex, 432, 1'b1, 2);
    end
`else
    for (int i = 1; i <= 314; i++) begin
      ex = (ex + 2 > 624) ? 624 : ex + 2;
      run_step($sformatf("right[%0d]", i), 4'b0100, 1'b0, ex, 432, 1'b1, 2);
    end
`endif

    // no tick: inputs change but state holds
    keys = 4'b0011;
    repeat (6) @(negedge clk);
    chk("notick.x", 32'(kid_x), 32'(ex));
    chk("notick.y", 32'(kid_y), 32'd432);
    chk("notick.jl", 32'(jumps_left), 32'd2);

    // restart beats the pending jump and consumes it
    run_step("restart", 4'b1000, 1'b0, 32, 432, 1'b1, 2);
    run_step("after_restart", 4'b0000, 1'b0, 32, 432, 1'b1, 2);

    // asynchronous reset mid-jump
    run_step("aj1", 4'b0010, 1'b0, 32, 424, 1'b0, 1);
    run_step("aj2", 4'b0010, 1'b0, 32, 417, 1'b0, 1);
    run_step("aj3", 4'b0010, 1'b0, 32, 411, 1'b0, 1);
    col = 10'd32; row = 10'd411;
    @(negedge clk);
    chk("air.is_kid", 32'(is_kid), 32'd1);
    chk("air.rgb", 32'(kid_rgb), 32'hFC0);
    #2;
    rst_n = 1'b0;
    keys = 4'b0000;
    #1;
    chk("arst.x", 32'(kid_x), 32'd32);
    chk("arst.y", 32'(kid_y), 32'd432);
    chk("arst.og", 32'(on_ground), 32'd1);
    chk("arst.jl", 32'(jumps_left), 32'd2);
    chk("arst.is_kid", 32'(is_kid), 32'd0);
    chk("arst.rgb", 32'(kid_rgb), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_step("post_rst", 4'b0000, 1'b0, 32, 432, 1'b1, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
